fpu_opload: RTL and testbench

Operand load and unpack stage directly upstream of the FPU exponent unit. Collects 32-bit operand words from the FPU input bus under a start/word handshake and assembles single or double operands A and B. Splits each operand into sign, 11-bit exponent and 53-bit significand, and classifies it. Presents the registered exponents on `aexpin`/`bexpin` with a one-cycle `op_valid` strobe for the exponent and mantissa datapaths.

---
 rtl/fpu_opload_pkg.sv | 15 +
 rtl/fpu_opclass.sv | 25 ++
 rtl/fpu_opload.sv | 95 +++++++++
 tb/tb_fpu_opload.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_opload_pkg.sv
// fpu_opload_pkg: shared states, class codes and field constants for operand load/unpack.
package fpu_opload_pkg;
  typedef enum logic [2:0] {S_IDLE, S_A_HI, S_A_LO, S_B_HI, S_B_LO, S_DONE} state_t;
  localparam logic [2:0] CLS_ZERO   = 3'b000;
  localparam logic [2:0] CLS_DENORM = 3'b001;
  localparam logic [2:0] CLS_NORMAL = 3'b010;
  localparam logic [2:0] CLS_INF    = 3'b011;
  localparam logic [2:0] CLS_QNAN   = 3'b100;
  localparam logic [2:0] CLS_SNAN   = 3'b101;
  localparam int TYPE_BIN   = 0;
  localparam int TYPE_DBL   = 1;
  localparam int TYPE_ABORT = 2;
  localparam int EXP_W_SGL  = 8;
  localparam int EXP_W_DBL  = 11;
endpackage

// File: rtl/fpu_opclass.sv
// fpu_opclass: classifies one unpacked operand and derives hidden bit and effective exponent.
module fpu_opclass
  import fpu_opload_pkg::*;
(
  input  logic [10:0] exp,
  input  logic [51:0] frac,
  input  logic        dprec,
  output logic [2:0]  cls,
  output logic        hidden,
  output logic [10:0] eff_exp
);
  logic exp_zero, frac_nz, exp_max;
  always_comb begin
    exp_zero = exp == '0;
    frac_nz  = |frac;
    exp_max  = dprec ? exp == {EXP_W_DBL{1'b1}}
                     : exp == {{(EXP_W_DBL-EXP_W_SGL){1'b0}}, {EXP_W_SGL{1'b1}}};
    cls      = exp_max  ? (!frac_nz ? CLS_INF : frac[51] ? CLS_QNAN : CLS_SNAN)
             : exp_zero ? (frac_nz ? CLS_DENORM : CLS_ZERO)
             : CLS_NORMAL;
    hidden   = !exp_zero;
    // denormals take the minimum normal exponent so the mantissa aligns without a shift
    eff_exp  = exp_zero ? {10'b0, frac_nz} : exp;
  end
endmodule

// File: rtl/fpu_opload.sv
// fpu_opload: collects operand words from the FPU bus and presents unpacked A/B operands.
module fpu_opload
  import fpu_opload_pkg::*;
(
  input  logic        clk,
  input  logic        reset_l,
  input  logic        fpuhold,
  input  logic        cyc0_rdy,
  input  logic [2:0]  cyc0_type,
  input  logic        din_vld,
  input  logic [31:0] din,
  output logic [10:0] aexpin,
  output logic [10:0] bexpin,
  output logic [52:0] amant,
  output logic [52:0] bmant,
  output logic        asign,
  output logic        bsign,
  output logic [2:0]  aclass,
  output logic [2:0]  bclass,
  output logic        dprec,
  output logic        op_valid,
  output logic        busy
);
  state_t state, nxt;
  logic        bin, idle_done, abort, start, acc, a_hid, b_hid;
  logic [10:0] a_exp, b_exp, hi_exp;
  logic [51:0] a_frac, b_frac, hi_frac;
  always_comb begin
    idle_done = state == S_IDLE || state == S_DONE;
    abort     = cyc0_rdy && cyc0_type[TYPE_ABORT] && !fpuhold;
    start     = cyc0_rdy && !cyc0_type[TYPE_ABORT] && !fpuhold && idle_done;
    acc       = din_vld && !fpuhold && !abort && !idle_done;
    hi_exp    = dprec ? din[30:20] : {3'b0, din[30:23]};
    hi_frac   = dprec ? {din[19:0], 32'b0} : {din[22:0], 29'b0};
    nxt       = fpuhold ? state
              : abort ? S_IDLE
              : idle_done ? (cyc0_rdy ? S_A_HI : S_IDLE)
              : !din_vld ? state
              : state == S_A_HI ? (dprec ? S_A_LO : bin ? S_B_HI : S_DONE)
              : state == S_A_LO ? (bin ? S_B_HI : S_DONE)
              : state == S_B_HI ? (dprec ? S_B_LO : S_DONE)
              : S_DONE;
  end
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state    <= S_IDLE;
      op_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= nxt;
      op_valid <= nxt == S_DONE;
      busy     <= nxt != S_IDLE && nxt != S_DONE;
    end
  end
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      dprec  <= 1'b0;
      bin    <= 1'b0;
      asign  <= 1'b0;
      bsign  <= 1'b0;
      a_exp  <= '0;
      b_exp  <= '0;
      a_frac <= '0;
      b_frac <= '0;
    end else if (start) begin
      dprec <= cyc0_type[TYPE_DBL];
      bin   <= cyc0_type[TYPE_BIN];
      if (!cyc0_type[TYPE_BIN]) begin
        bsign  <= 1'b0;
        b_exp  <= '0;
        b_frac <= '0;
      end
    end else if (acc) begin
      case (state)
        S_A_HI: begin
          asign  <= din[31];
          a_exp  <= hi_exp;
          a_frac <= hi_frac;
        end
        S_A_LO: a_frac[31:0] <= din;
        S_B_HI: begin
          bsign  <= din[31];
          b_exp  <= hi_exp;
          b_frac <= hi_frac;
        end
        S_B_LO: b_frac[31:0] <= din;
        default: ;
      endcase
    end
  end
  fpu_opclass u_a (.exp(a_exp), .frac(a_frac), .dprec(dprec), .cls(aclass), .hidden(a_hid), .eff_exp(aexpin));
  fpu_opclass u_b (.exp(b_exp), .frac(b_frac), .dprec(dprec), .cls(bclass), .hidden(b_hid), .eff_exp(bexpin));
  assign amant = {a_hid, a_frac};
  assign bmant = {b_hid, b_frac};
endmodule

// File: tb/tb_fpu_opload.sv
// tb_fpu_opload: directed vector table plus stall/abort/reset sequences for fpu_opload.
module tb_fpu_opload;
  logic        clk = 1'b0, reset_l = 1'b0, fpuhold = 1'b0, cyc0_rdy = 1'b0, din_vld = 1'b0;
  logic [2:0]  cyc0_type = 3'b0;
  logic [31:0] din = 32'b0;
  logic [10:0] aexpin, bexpin;
  logic [52:0] amant, bmant;
  logic        asign, bsign, dprec, op_valid, busy;
  logic [2:0]  aclass, bclass;
  int total = 0, bad = 0;

  fpu_opload dut (
    .clk(clk), .reset_l(reset_l), .fpuhold(fpuhold), .cyc0_rdy(cyc0_rdy), .cyc0_type(cyc0_type),
    .din_vld(din_vld), .din(din), .aexpin(aexpin), .bexpin(bexpin), .amant(amant), .bmant(bmant),
    .asign(asign), .bsign(bsign), .aclass(aclass), .bclass(bclass), .dprec(dprec),
    .op_valid(op_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       typ;
    logic [3:0][31:0] w;
    int               n;
    logic [10:0]      aexp, bexp;
    logic [52:0]      am, bm;
    logic             as, bs, dp;
    logic [2:0]       ac, bc;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic [2:0] typ, input logic [31:0] w0, w1, w2, w3, input int n,
                              input logic [10:0] aexp, input logic [52:0] am, input logic as, input logic [2:0] ac,
                              input logic [10:0] bexp, input logic [52:0] bm, input logic bs, input logic [2:0] bc,
                              input logic dp);
    vec_t v;
    v.typ = typ; v.w = {w3, w2, w1, w0}; v.n = n;
    v.aexp = aexp; v.am = am; v.as = as; v.ac = ac;
    v.bexp = bexp; v.bm = bm; v.bs = bs; v.bc = bc; v.dp = dp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] typ);
    cyc0_rdy = 1'b1; cyc0_type = typ;
    cycle();
    cyc0_rdy = 1'b0; cyc0_type = 3'b0;
  endtask

  task automatic word(input logic [31:0] w);
    din_vld = 1'b1; din = w;
    cycle();
    din_vld = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_aexp"}, 64'(aexpin), 64'd0);
    chk({nm, "_bexp"}, 64'(bexpin), 64'd0);
    chk({nm, "_amant"}, 64'(amant), 64'd0);
    chk({nm, "_bmant"}, 64'(bmant), 64'd0);
    chk({nm, "_signs"}, {62'd0, asign, bsign}, 64'd0);
    chk({nm, "_classes"}, {58'd0, aclass, bclass}, 64'd0);
    chk({nm, "_flags"}, {61'd0, dprec, op_valid, busy}, 64'd0);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    string nm;
    v = vecs[i];
    nm = $sformatf("v%0d", i);
    start_op(v.typ);
    chk({nm, "_busy_start"}, 64'(busy), 64'd1);
    for (int k = 0; k < v.n; k++) begin
      word(v.w[k]);
      chk($sformatf("%s_valid_w%0d", nm, k), 64'(op_valid), (k == v.n - 1) ? 64'd1 : 64'd0);
    end
    chk({nm, "_aexp"}, 64'(aexpin), 64'(v.aexp));
    chk({nm, "_amant"}, 64'(amant), 64'(v.am));
    chk({nm, "_asign"}, 64'(asign), 64'(v.as));
    chk({nm, "_aclass"}, 64'(aclass), 64'(v.ac));
    chk({nm, "_bexp"}, 64'(bexpin), 64'(v.bexp));
    chk({nm, "_bmant"}, 64'(bmant), 64'(v.bm));
    chk({nm, "_bsign"}, 64'(bsign), 64'(v.bs));
    chk({nm, "_bclass"}, 64'(bclass), 64'(v.bc));
    chk({nm, "_dprec"}, 64'(dprec), 64'(v.dp));
    chk({nm, "_busy_done"}, 64'(busy), 64'd0);
    cycle();
    chk({nm, "_valid_drop"}, 64'(op_valid), 64'd0);
  endtask

  localparam logic [52:0] ONE = 53'h10000000000000;

  initial begin
    vecs[0] = mk(3'b001, 32'h3F800000, 32'h40000000, 0, 0, 2, 11'h07F, ONE, 0, 3'b010, 11'h080, ONE, 0, 3'b010, 0);
    vecs[1] = mk(3'b010, 32'h3FF00000, 32'h00000001, 0, 0, 2, 11'h3FF, 53'h10000000000001, 0, 3'b010, 0, 0, 0, 3'b000, 1);
    vecs[2] = mk(3'b000, 32'h00000001, 0, 0, 0, 1, 11'h001, 53'h00000020000000, 0, 3'b001, 0, 0, 0, 3'b000, 0);
    vecs[3] = mk(3'b000, 32'h7F800000, 0, 0, 0, 1, 11'h0FF, ONE, 0, 3'b011, 0, 0, 0, 3'b000, 0);
    vecs[4] = mk(3'b000, 32'h7FC00000, 0, 0, 0, 1, 11'h0FF, 53'h18000000000000, 0, 3'b100, 0, 0, 0, 3'b000, 0);
    vecs[5] = mk(3'b000, 32'h7F800001, 0, 0, 0, 1, 11'h0FF, 53'h10000020000000, 0, 3'b101, 0, 0, 0, 3'b000, 0);
    vecs[6] = mk(3'b000, 32'h80000000, 0, 0, 0, 1, 11'h000, 0, 1, 3'b000, 0, 0, 0, 3'b000, 0);
    vecs[7] = mk(3'b011, 32'hC0000000, 32'h00000000, 32'h7FF80000, 32'h00000000, 4,
                 11'h400, ONE, 1, 3'b010, 11'h7FF, 53'h18000000000000, 0, 3'b100, 1);

    #12;
    check_all_zero("reset");
    reset_l = 1'b1;
    cycle();

    for (int i = 0; i < 8; i++) run_vec(i);

    // stall three cycles in A_LO with a word pending
    start_op(3'b010);
    word(32'h3FF00000);
    din_vld = 1'b1; din = 32'h00000001; fpuhold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk($sformatf("hold%0d_amant", k), 64'(amant), 64'(ONE));
      chk($sformatf("hold%0d_aexp", k), 64'(aexpin), 64'h3FF);
      chk($sformatf("hold%0d_valid", k), 64'(op_valid), 64'd0);
      chk($sformatf("hold%0d_busy", k), 64'(busy), 64'd1);
    end
    fpuhold = 1'b0;
    cycle();
    din_vld = 1'b0;
    chk("hold_release_valid", 64'(op_valid), 64'd1);
    chk("hold_release_amant", 64'(amant), 64'h10000000000001);
    fpuhold = 1'b1;
    cycle();
    cycle();
    chk("hold_done_valid", 64'(op_valid), 64'd1);
    fpuhold = 1'b0;
    cycle();
    chk("hold_done_exit", 64'(op_valid), 64'd0);

    // abort in B_HI with a word on the bus; B was cleared by the previous unary op
    start_op(3'b011);
    word(32'h40000000);
    word(32'h00000000);
    cyc0_rdy = 1'b1; cyc0_type = 3'b100; din_vld = 1'b1; din = 32'h7FF00000;
    cycle();
    cyc0_rdy = 1'b0; cyc0_type = 3'b0; din_vld = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(op_valid), 64'd0);
    chk("abort_bexp_kept", 64'(bexpin), 64'd0);
    chk("abort_aexp_kept", 64'(aexpin), 64'h400);
    cycle();
    chk("abort_valid_later", 64'(op_valid), 64'd0);
    start_op(3'b000);
    word(32'h3F800000);
    chk("post_abort_valid", 64'(op_valid), 64'd1);
    chk("post_abort_aexp", 64'(aexpin), 64'h07F);
    chk("post_abort_dprec", 64'(dprec), 64'd0);
    cycle();

    // asynchronous reset in A_LO
    start_op(3'b010);
    word(32'h3FF00000);
    #2 reset_l = 1'b0;
    #1 check_all_zero("midrst");
    #1 reset_l = 1'b1;
    cycle();
    chk("midrst_idle_valid", 64'(op_valid), 64'd0);
    start_op(3'b000);
    word(32'h3F800000);
    chk("b2b_first_valid", 64'(op_valid), 64'd1);
    start_op(3'b000);
    chk("b2b_restart_busy", 64'(busy), 64'd1);
    chk("b2b_restart_valid", 64'(op_valid), 64'd0);
    word(32'h40000000);
    chk("b2b_second_valid", 64'(op_valid), 64'd1);
    chk("b2b_second_aexp", 64'(aexpin), 64'h080);
    chk("b2b_second_class", 64'(aclass), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
